// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and helpers for the LCD row writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_WAIT
  } phase_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int FRAME_BYTES = 34;
  localparam int LINE2_IDX   = FRAME_BYTES / 2;

  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic logic [7:0] init_cmd(logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Char 0 sits in the top byte of the row vector.
  function automatic logic [7:0] row_char(logic [127:0] row, logic [3:0] idx);
    return row[{4'd15 - idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_row_writer_if.sv
// HD44780 pin bundle: the byte transmitter drives it, observers read it.
interface lcd_row_writer_if;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] data;

  modport master (output rs, rw, en, data);
  modport slave  (input  rs, rw, en, data);
endinterface

// File: rtl/lcd_byte_tx.sv
// One HD44780 byte: setup clock, EN_CYCLES of en=1, then a wait gap (longer after clear).
// byte_done marks the last wait clock so the next byte_start can follow with no gap.
module lcd_byte_tx import lcd_pkg::*; #(
  parameter int EN_CYCLES       = 2,
  parameter int WAIT_CYCLES     = 3,
  parameter int CLR_WAIT_CYCLES = 10,
  parameter int CW              = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_start,
  input  logic             byte_rs,
  input  logic [7:0]       byte_data,
  input  logic             byte_clr,
  output logic             byte_done,
  lcd_row_writer_if.master lcd
);

  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   wait_last;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            clr_q, clr_d;

  assign wait_last = clr_q ? CW'(CLR_WAIT_CYCLES - 1) : CW'(WAIT_CYCLES - 1);
  assign byte_done = (phase_q == PH_WAIT) && (cnt_q == wait_last);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    clr_d   = clr_q;
    case (phase_q)
      PH_SETUP: begin
        phase_d = PH_EN;
        cnt_d   = '0;
      end
      PH_EN: begin
        if (cnt_q == CW'(EN_CYCLES - 1)) begin
          phase_d = PH_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_WAIT: begin
        if (byte_done) begin
          phase_d = PH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (byte_start && ((phase_q == PH_IDLE) || byte_done)) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
      rs_d    = byte_rs;
      data_d  = byte_data;
      clr_d   = byte_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      clr_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
    end
  end

  // rs/data are held from setup until the next byte loads, so they never move under en.
  assign lcd.en   = (phase_q == PH_EN);
  assign lcd.rs   = rs_q;
  assign lcd.rw   = 1'b0;
  assign lcd.data = data_q;

endmodule

// File: rtl/lcd_row_writer.sv
// Writes two 16-char rows to an HD44780 after power-up/INIT; one 34-byte frame per request.
// LCD_AUTO_REFRESH_EN: while idle, any row change versus the last snapshot also starts a frame.
module lcd_row_writer import lcd_pkg::*; #(
  parameter int EN_CYCLES       = 2,
  parameter int WAIT_CYCLES     = 3,
  parameter int CLR_WAIT_CYCLES = 10,
  parameter int POWERUP_CYCLES  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  input  logic         update,
  output logic         busy,
  output logic         done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data
);

  localparam int CW = cnt_width(EN_CYCLES, WAIT_CYCLES, CLR_WAIT_CYCLES, POWERUP_CYCLES);

  state_e         state_q, state_d;
  logic [CW-1:0]  pu_q, pu_d;
  logic [1:0]     init_q, init_d;
  logic [5:0]     byte_q, byte_d;
  logic [3:0]     char_q, char_d;
  logic           pending_q, pending_d;
  logic [127:0]   sh1_q, sh1_d, sh2_q, sh2_d;
  logic [5:0]     nb;
  logic           frame_req;
  logic           go_load;

  logic           tx_start, tx_rs, tx_clr, tx_done;
  logic [7:0]     tx_data;

  lcd_row_writer_if lcd_bus ();

  lcd_byte_tx #(
    .EN_CYCLES       (EN_CYCLES),
    .WAIT_CYCLES     (WAIT_CYCLES),
    .CLR_WAIT_CYCLES (CLR_WAIT_CYCLES),
    .CW              (CW)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .byte_start (tx_start),
    .byte_rs    (tx_rs),
    .byte_data  (tx_data),
    .byte_clr   (tx_clr),
    .byte_done  (tx_done),
    .lcd        (lcd_bus)
  );

`ifdef LCD_AUTO_REFRESH_EN
  assign frame_req = update || (row1 != sh1_q) || (row2 != sh2_q);
`else
  assign frame_req = update;
`endif

  assign nb      = byte_q + 6'd1;
  assign go_load = pending_q || update;

  always_comb begin
    state_d   = state_q;
    pu_d      = pu_q;
    init_d    = init_q;
    byte_d    = byte_q;
    char_d    = char_q;
    pending_d = pending_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    tx_start  = 1'b0;
    tx_rs     = 1'b0;
    tx_data   = 8'h00;
    tx_clr    = 1'b0;
    done      = 1'b0;
    if (update && (state_q != IDLE)) pending_d = 1'b1;
    case (state_q)
      POWERUP: begin
        if (pu_q == CW'(POWERUP_CYCLES - 1)) begin
          state_d  = INIT;
          init_d   = 2'd0;
          tx_start = 1'b1;
          tx_data  = init_cmd(2'd0);
        end else begin
          pu_d = pu_q + 1'b1;
        end
      end
      INIT: begin
        if (tx_done) begin
          if (init_q == 2'd3) begin
            state_d   = go_load ? LOAD : IDLE;
            pending_d = 1'b0;
          end else begin
            init_d   = init_q + 2'd1;
            tx_start = 1'b1;
            tx_data  = init_cmd(init_q + 2'd1);
            tx_clr   = (init_cmd(init_q + 2'd1) == CMD_CLEAR);
          end
        end
      end
      IDLE: begin
        if (frame_req) state_d = LOAD;
      end
      LOAD: begin
        sh1_d    = row1;
        sh2_d    = row2;
        byte_d   = 6'd0;
        char_d   = 4'd0;
        tx_start = 1'b1;
        tx_data  = CMD_LINE1;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_done) begin
          if (byte_q == 6'(FRAME_BYTES - 1)) begin
            state_d = DONE;
          end else begin
            byte_d   = nb;
            tx_start = 1'b1;
            if (nb == 6'(LINE2_IDX)) begin
              tx_data = CMD_LINE2;
              char_d  = 4'd0;
            end else begin
              tx_rs   = 1'b1;
              tx_data = row_char((nb < 6'(LINE2_IDX)) ? sh1_q : sh2_q, char_q);
              char_d  = (char_q == 4'd15) ? 4'd15 : char_q + 4'd1;
            end
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_d   = go_load ? LOAD : IDLE;
        pending_d = 1'b0;
      end
      default: state_d = POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= POWERUP;
      pu_q      <= '0;
      init_q    <= 2'd0;
      byte_q    <= 6'd0;
      char_q    <= 4'd0;
      pending_q <= 1'b0;
      sh1_q     <= '0;
      sh2_q     <= '0;
    end else begin
      state_q   <= state_d;
      pu_q      <= pu_d;
      init_q    <= init_d;
      byte_q    <= byte_d;
      char_q    <= char_d;
      pending_q <= pending_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign lcd_rs   = lcd_bus.rs;
  assign lcd_rw   = lcd_bus.rw;
  assign lcd_en   = lcd_bus.en;
  assign lcd_data = lcd_bus.data;

endmodule

// File: tb/tb_lcd_row_writer.sv
// Bench for lcd_row_writer: scoreboard of expected LCD bytes checked at each lcd_en rise.
module tb_lcd_row_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] row1 = '0;
  logic [127:0] row2 = '0;
  logic         update = 1'b0;
  logic         busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;

  always #5 clk = ~clk;

  lcd_row_writer dut (
    .clk      (clk),
    .rst      (rst),
    .row1     (row1),
    .row2     (row2),
    .update   (update),
    .busy     (busy),
    .done     (done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  lcd_row_writer_if bus ();
  assign bus.rs   = lcd_rs;
  assign bus.rw   = lcd_rw;
  assign bus.en   = lcd_en;
  assign bus.data = lcd_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_bytes = 0;
  int         n_done = 0;
  logic [8:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h06});
    sb.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
    sb.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, r1[127 - 8*i -: 8]});
    sb.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, r2[127 - 8*i -: 8]});
  endtask

  // Bus monitor: pops the scoreboard on every en rise and checks setup/hold and en width.
  logic       en_prev = 1'b0;
  logic [8:0] prev_bus = '0;
  logic [8:0] cap = '0;
  logic [8:0] exp_b;
  int         hi_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      hi_len = 0;
    end else begin
      if (bus.en && !en_prev) begin
        n_bytes++;
        check("setup_valid", {bus.rs, bus.data}, prev_bus);
        check("rw_low", bus.rw, 0);
        if (sb.size() == 0) begin
          check("extra_byte", 1, 0);
        end else begin
          exp_b = sb.pop_front();
          check("byte", {bus.rs, bus.data}, exp_b);
        end
        cap    = {bus.rs, bus.data};
        hi_len = 1;
      end else if (bus.en) begin
        check("en_stable", {bus.rs, bus.data}, cap);
        hi_len++;
      end else if (en_prev) begin
        check("en_width", hi_len, 2);
      end
      if (done) n_done++;
    end
    en_prev  = bus.en && !rst;
    prev_bus = {bus.rs, bus.data};
  end

  initial begin
    int k;
    logic [127:0] r1a, r2a, r1b, r2b;
    r1a = {"FA", {14{8'h20}}};
    r2a = {16{"C"}};
    r1b = {"B", {15{8'h20}}};
    r2b = {16{"D"}};

    // Reset and power-up/INIT timing
    step();
    step();
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    push_init();
    rst = 1'b0;
    repeat (7) step();
    check("pu_quiet_data", lcd_data, 8'h00);
    step();
    check("setup_data", lcd_data, 8'h38);
    check("setup_en", lcd_en, 0);
    step();
    check("first_en", lcd_en, 1);
    repeat (29) step();
    check("init_busy", busy, 1);
    step();
    check("init_idle", busy, 0);
    check("init_sb_empty", sb.size(), 0);

    // Single frame
    n_bytes = 0;
    n_done  = 0;
    row1 = r1a;
    row2 = r2a;
    push_frame(r1a, r2a);
    update = 1'b1;
    step();
    update = 1'b0;
    k = 1;
    while (!done && k < 2000) begin step(); k++; end
    check("frame_latency", k, 206);
    step();
    check("done_pulse_width", done, 0);
    check("frame_idle", busy, 0);
    check("frame_bytes", n_bytes, 34);
    check("frame_done_cnt", n_done, 1);
    check("frame_sb_empty", sb.size(), 0);

    // Re-request mid-frame with new rows: old frame intact, second frame follows
    n_bytes = 0;
    n_done  = 0;
    push_frame(r1a, r2a);
    update = 1'b1;
    step();
    update = 1'b0;
    k = 0;
    while (n_bytes < 10 && k < 500) begin step(); k++; end
    check("reach_byte10", n_bytes, 10);
    row1 = r1b;
    row2 = r2b;
    push_frame(r1b, r2b);
    update = 1'b1;
    step();
    update = 1'b0;
    k = 0;
    while (!done && k < 500) begin step(); k++; end
    step();
    k = 1;
    while (!done && k < 500) begin step(); k++; end
    check("second_frame_gap", k, 206);
    step();
    check("two_done_pulses", n_done, 2);
    check("two_frame_bytes", n_bytes, 68);
    check("two_frame_sb_empty", sb.size(), 0);

    // Reset during en=1 of byte 5
    n_bytes = 0;
    n_done  = 0;
    push_frame(r1b, r2b);
    update = 1'b1;
    step();
    update = 1'b0;
    k = 0;
    while (!(n_bytes == 6 && lcd_en) && k < 500) begin step(); k++; end
    check("abort_point_en", lcd_en, 1);
    rst = 1'b1;
    sb.delete();
    step();
    check("abort_en_low", lcd_en, 0);
    check("abort_busy", busy, 1);
    check("abort_no_done", done, 0);
    step();
    push_init();
`ifdef LCD_AUTO_REFRESH_EN
    push_frame(r1b, r2b);
`endif
    rst = 1'b0;
    k = 0;
    while (busy && k < 500) begin step(); k++; end
    check("reinit_latency", k, 39);
    check("reinit_no_done", n_done, 0);
`ifdef LCD_AUTO_REFRESH_EN
    k = 0;
    while (!done && k < 500) begin step(); k++; end
    step();
`endif
    check("reinit_sb_empty", sb.size(), 0);

    // Row change while idle with no update
    n_bytes = 0;
    row2 = {{15{"D"}}, 8'h44};
`ifdef LCD_AUTO_REFRESH_EN
    row2 = {{15{"D"}}, 8'h43};
    step();
    k = 0;
    while (busy && k < 500) begin step(); k++; end
    n_bytes = 0;
    row2 = {{15{"D"}}, 8'h44};
    push_frame(r1b, row2);
    step();
    step();
    check("auto_started", busy, 1);
    k = 0;
    while (!done && k < 500) begin step(); k++; end
    step();
    check("auto_bytes", n_bytes, 34);
    check("auto_sb_empty", sb.size(), 0);
`else
    repeat (300) step();
    check("no_auto_bytes", n_bytes, 0);
    check("no_auto_busy", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
